// File: rtl/jtag_tap_sequencer_if.sv
// jtag_tap_sequencer_if: command/response bus of the JTAG TAP sequencer.
//   master : cmd_valid/cmd_op/cmd_len/cmd_data out, cmd_ready and rsp_* in
//   slave  : the sequencer side (directions mirrored)
//   cmd_op : 0=TAP reset, 1=shift IR, 2=shift DR, 3=run-test-idle clocking
//   rsp_*  : rsp_valid one-cycle completion pulse, rsp_err/rsp_data held until next response
interface jtag_tap_sequencer_if #(
    parameter int MAX_WIDTH = 32,
    parameter int LEN_W     = 6
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [LEN_W-1:0]     cmd_len;
    logic [MAX_WIDTH-1:0] cmd_data;
    logic                 rsp_valid;
    logic                 rsp_err;
    logic [MAX_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: JTAG TAP master. Takes one command at a time (TAP reset,
// IR shift, DR shift, run-test-idle clocking), drives TCK/TMS/TDI from clk with
// a TCK half-period of HALF_DIV clk cycles, captures TDO during shifts and
// returns it with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst        fabric clock, synchronous active-high reset
//   bus (slave)     command/response handshake (jtag_tap_sequencer_if)
//   busy            a sequence (including its response cycle) is in progress
//   tck, tms, tdi   JTAG outputs; tdo JTAG input
// Optional build macro JTAG_SEQ_AUTO_RESET_EN: after reset the block runs the
// TAP reset sequence on its own (no rsp_valid) before raising cmd_ready.
module jtag_tap_sequencer #(
    parameter int MAX_WIDTH = 32,
    parameter int LEN_W     = 6,
    parameter int HALF_DIV  = 2
) (
    input  logic                clk,
    input  logic                rst,
    jtag_tap_sequencer_if.slave bus,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);
    // cnt must also index the 8-bit reset header
    localparam int CW = (LEN_W > 4) ? LEN_W : 4;
    localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;
    state_t state;

    logic [1:0]           op_q;
    logic [CW-1:0]        len_q, cnt, cnt_nx, pre_last;
    logic [7:0]           pre_pat;
    logic [MAX_WIDTH-1:0] data_q, cap;
    logic [HW-1:0]        half_cnt;
    logic                 rti;     // run-test-idle clocking: TMS=0, TDI=0, no capture
    logic                 quiet;   // internal reset sequence, no response pulse
    logic                 phase_end, bit_done, sample, last_shift, fin, len_bad;

    assign cnt_nx     = cnt + 1'b1;
    assign phase_end  = (half_cnt == HALF_LAST);
    assign bit_done   = tck && phase_end;              // end of a TCK high phase
    assign sample     = tck && (half_cnt == '0) && (state == S_SHIFT) && !rti;
    assign last_shift = (cnt == len_q - 1'b1);
    assign fin        = bit_done &&
                        ((state == S_PRE   && cnt == pre_last && op_q == 2'd0) ||
                         (state == S_SHIFT && last_shift && rti) ||
                         (state == S_POST  && cnt == CW'(2)));
    assign len_bad    = (bus.cmd_op == 2'd1 || bus.cmd_op == 2'd2) &&
                        (bus.cmd_len == '0 || bus.cmd_len > LEN_W'(MAX_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
            busy          <= 1'b0;
            tck           <= 1'b0;
            tms           <= 1'b1;
            tdi           <= 1'b0;
            half_cnt      <= '0;
            cnt           <= '0;
            op_q          <= 2'd0;
            len_q         <= '0;
            data_q        <= '0;
            cap           <= '0;
            pre_pat       <= 8'h00;
            pre_last      <= '0;
            rti           <= 1'b0;
            quiet         <= 1'b0;
`ifdef JTAG_SEQ_AUTO_RESET_EN
            // park in the first low phase of a TAP reset; it starts once rst drops
            state         <= S_PRE;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            pre_pat       <= 8'h3F;
            pre_last      <= CW'(7);
            quiet         <= 1'b1;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        op_q          <= bus.cmd_op;
                        len_q         <= CW'(bus.cmd_len);
                        data_q        <= bus.cmd_data;
                        cap           <= '0;
                        half_cnt      <= '0;
                        cnt           <= '0;
                        rti           <= 1'b0;
                        quiet         <= 1'b0;
                        tdi           <= 1'b0;
                        if (len_bad) begin
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_data  <= '0;
                        end else begin
                            case (bus.cmd_op)
                                2'd0: begin
                                    state <= S_PRE; pre_pat <= 8'h3F; pre_last <= CW'(7); tms <= 1'b1;
                                end
                                2'd1: begin
                                    state <= S_PRE; pre_pat <= 8'h03; pre_last <= CW'(3); tms <= 1'b1;
                                end
                                2'd2: begin
                                    state <= S_PRE; pre_pat <= 8'h02; pre_last <= CW'(3); tms <= 1'b0;
                                end
                                default: begin
                                    tms <= 1'b0;
                                    rti <= 1'b1;
                                    if (bus.cmd_len == '0) begin
                                        state         <= S_RESP;
                                        bus.rsp_valid <= 1'b1;
                                        bus.rsp_err   <= 1'b0;
                                        bus.rsp_data  <= '0;
                                    end else begin
                                        state <= S_SHIFT;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_RESP: begin
                    state         <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: begin
                    // TCK generator shared by PRE/SHIFT/POST
                    if (phase_end) begin
                        half_cnt <= '0;
                        tck      <= ~tck;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                    if (sample)
                        cap[cnt] <= tdo;
                    if (fin) begin
                        tdi <= 1'b0;
                        if (quiet) begin
                            state         <= S_IDLE;
                            bus.cmd_ready <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            // last capture lands 3 TCKs earlier, so cap is complete here
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_data  <= cap;
                        end
                    end else if (bit_done) begin
                        case (state)
                            S_PRE: begin
                                if (cnt == pre_last) begin
                                    state <= S_SHIFT;
                                    cnt   <= '0;
                                    tms   <= (len_q == CW'(1));
                                    tdi   <= data_q[0];
                                end else begin
                                    cnt <= cnt_nx;
                                    tms <= pre_pat[cnt_nx[2:0]];
                                end
                            end
                            S_SHIFT: begin
                                if (last_shift) begin
                                    state <= S_POST;
                                    cnt   <= '0;
                                    tms   <= 1'b1;
                                    tdi   <= 1'b0;
                                end else begin
                                    cnt <= cnt_nx;
                                    tms <= !rti && (cnt_nx == len_q - 1'b1);
                                    tdi <= !rti && data_q[cnt_nx];
                                end
                            end
                            default: begin
                                cnt <= cnt_nx;
                                tms <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Directed bench for jtag_tap_sequencer: u0 runs at HALF_DIV=2, u1 at HALF_DIV=1.
module tb_jtag_tap_sequencer;
    localparam int MW = 32;
    localparam int LW = 6;
`ifdef JTAG_SEQ_AUTO_RESET_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, tck0, tms0, tdi0, tdo0;
    logic busy1, tck1, tms1, tdi1, tdo1;
    logic loop0 = 1'b0;
    int   checks = 0;
    int   failures = 0;

    jtag_tap_sequencer_if #(.MAX_WIDTH(MW), .LEN_W(LW)) bus0 ();
    jtag_tap_sequencer_if #(.MAX_WIDTH(MW), .LEN_W(LW)) bus1 ();

    assign tdo0 = loop0 ? tdi0 : 1'b0;
    assign tdo1 = 1'b0;

    jtag_tap_sequencer #(.MAX_WIDTH(MW), .LEN_W(LW), .HALF_DIV(2)) u0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0),
        .tck(tck0), .tms(tms0), .tdi(tdi0), .tdo(tdo0)
    );
    jtag_tap_sequencer #(.MAX_WIDTH(MW), .LEN_W(LW), .HALF_DIV(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
        .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo1)
    );

    always #5 clk = ~clk;

    // TCK rise logs (TMS/TDI seen while TCK high), response and accept counters
    bit tms_log0 [0:1023];
    bit tdi_log0 [0:1023];
    bit tms_log1 [0:1023];
    bit tdi_log1 [0:1023];
    int n0 = 0, n1 = 0, nrsp0 = 0, nacc1 = 0;
    logic tck0_d = 1'b0, tck1_d = 1'b0;

    always @(negedge clk) begin
        if (tck0 === 1'b1 && tck0_d !== 1'b1 && n0 < 1024) begin
            tms_log0[n0] = tms0; tdi_log0[n0] = tdi0; n0++;
        end
        if (tck1 === 1'b1 && tck1_d !== 1'b1 && n1 < 1024) begin
            tms_log1[n1] = tms1; tdi_log1[n1] = tdi1; n1++;
        end
        tck0_d = tck0;
        tck1_d = tck1;
        if (bus0.rsp_valid === 1'b1) nrsp0++;
    end

    always @(posedge clk)
        if (bus1.cmd_valid === 1'b1 && bus1.cmd_ready === 1'b1) nacc1++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input bit s, input bit want_tdi, input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++)
            if (base + i < 1024)
                v[i] = s ? (want_tdi ? tdi_log1[base+i] : tms_log1[base+i])
                         : (want_tdi ? tdi_log0[base+i] : tms_log0[base+i]);
        return v;
    endfunction

    // Issue one command; rel = cycle of rsp_valid counting the accept edge as
    // cycle 0 (-1 on timeout). hold keeps cmd_valid up until the response.
    task automatic go(input bit s, input logic [1:0] op, input logic [5:0] len,
                      input logic [31:0] d, input bit hold, output int rel, output int base);
        @(negedge clk);
        if (!s) begin
            base = n0;
            bus0.cmd_op = op; bus0.cmd_len = len; bus0.cmd_data = d; bus0.cmd_valid = 1'b1;
        end else begin
            base = n1;
            bus1.cmd_op = op; bus1.cmd_len = len; bus1.cmd_data = d; bus1.cmd_valid = 1'b1;
        end
        @(negedge clk);
        if (!hold) begin
            bus0.cmd_valid = 1'b0; bus1.cmd_valid = 1'b0;
        end
        rel = -1;
        for (int i = 1; i < 400; i++) begin
            if ((!s && bus0.rsp_valid === 1'b1) || (s && bus1.rsp_valid === 1'b1)) begin
                rel = i;
                break;
            end
            @(negedge clk);
        end
        bus0.cmd_valid = 1'b0;
        bus1.cmd_valid = 1'b0;
    endtask

    // Bounded wait for both sequencers to report ready
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus0.cmd_ready === 1'b1 && bus1.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int rel, base, r0, a0;
        bit ok;
        bus0.cmd_valid = 1'b0; bus0.cmd_op = 2'd0; bus0.cmd_len = '0; bus0.cmd_data = '0;
        bus1.cmd_valid = 1'b0; bus1.cmd_op = 2'd0; bus1.cmd_len = '0; bus1.cmd_data = '0;
        repeat (3) @(negedge clk);

        // reset values while rst is held
        chk("rst_ready", bus0.cmd_ready, AUTO ? 64'd0 : 64'd1);
        chk("rst_busy",  busy0, AUTO ? 64'd1 : 64'd0);
        chk("rst_rspv",  bus0.rsp_valid, 64'd0);
        chk("rst_err",   bus0.rsp_err, 64'd0);
        chk("rst_data",  bus0.rsp_data, 64'd0);
        chk("rst_tck",   tck0, 64'd0);
        chk("rst_tms",   tms0, 64'd1);
        chk("rst_tdi",   tdi0, 64'd0);
        rst = 1'b0;
        if (AUTO) begin
            wait_ready(ok);
            chk("auto_ready", ok, 64'd1);
            chk("auto_rises", n0, 64'd8);
            chk("auto_tms", pk(0, 0, 0, 8), 64'h3F);
            chk("auto_norsp", nrsp0, 64'd0);
        end

        // op 0: TAP reset, 8 TCKs, response at cycle 33
        go(0, 2'd0, 6'd0, 32'h0, 0, rel, base);
        chk("op0_lat",   rel, 64'd33);
        chk("op0_rises", n0 - base, 64'd8);
        chk("op0_tms",   pk(0, 0, base, 8), 64'h3F);
        chk("op0_err",   bus0.rsp_err, 64'd0);
        chk("op0_data",  bus0.rsp_data, 64'd0);

        // op 1: IR shift LEN=10, TMS 1,1,0,0 | 0x9,1 | 1,0,0
        go(0, 2'd1, 6'd10, 32'h3C2, 0, rel, base);
        chk("ir_lat",   rel, 64'd69);
        chk("ir_rises", n0 - base, 64'd17);
        chk("ir_tms",   pk(0, 0, base, 17), 64'h6003);
        chk("ir_tdi",   pk(0, 1, base, 17), 64'h3C20);
        chk("ir_err",   bus0.rsp_err, 64'd0);
        chk("ir_data",  bus0.rsp_data, 64'd0);
        chk("ir_ready", bus0.cmd_ready, 64'd0);

        // op 2: DR shift LEN=12 with TDO looped to TDI
        loop0 = 1'b1;
        go(0, 2'd2, 6'd12, 32'h95B, 0, rel, base);
        chk("dr_lat",   rel, 64'd77);
        chk("dr_rises", n0 - base, 64'd19);
        chk("dr_tms",   pk(0, 0, base, 19), 64'h18002);
        chk("dr_data",  bus0.rsp_data, 64'h95B);
        chk("dr_err",   bus0.rsp_err, 64'd0);

        // op 1 at LEN=MAX_WIDTH is legal
        go(0, 2'd1, 6'd32, 32'hA5A51234, 0, rel, base);
        chk("max_lat",   rel, 64'd157);
        chk("max_rises", n0 - base, 64'd39);
        chk("max_data",  bus0.rsp_data, 64'hA5A51234);
        chk("max_err",   bus0.rsp_err, 64'd0);
        loop0 = 1'b0;

        // rejected lengths: immediate error response, no TCK
        go(0, 2'd2, 6'd0, 32'hFFFF, 0, rel, base);
        chk("len0_lat",   rel, 64'd1);
        chk("len0_err",   bus0.rsp_err, 64'd1);
        chk("len0_data",  bus0.rsp_data, 64'd0);
        chk("len0_rises", n0 - base, 64'd0);
        go(0, 2'd2, 6'd33, 32'hFFFF, 0, rel, base);
        chk("len33_lat",   rel, 64'd1);
        chk("len33_err",   bus0.rsp_err, 64'd1);
        chk("len33_rises", n0 - base, 64'd0);

        // op 3 at HALF_DIV=1 with cmd_valid held through busy
        a0 = nacc1;
        go(1, 2'd3, 6'd5, 32'hFFFFFFFF, 1, rel, base);
        chk("rti_lat",   rel, 64'd11);
        chk("rti_rises", n1 - base, 64'd5);
        chk("rti_tms",   pk(1, 0, base, 5), 64'h0);
        chk("rti_tdi",   pk(1, 1, base, 5), 64'h0);
        chk("rti_acc",   nacc1 - a0, 64'd1);
        chk("rti_err",   bus1.rsp_err, 64'd0);
        go(1, 2'd3, 6'd0, 32'h0, 0, rel, base);
        chk("rti0_lat",   rel, 64'd1);
        chk("rti0_err",   bus1.rsp_err, 64'd0);
        chk("rti0_rises", n1 - base, 64'd0);

        // rst during the 6th TCK of an IR shift
        @(negedge clk);
        base = n0;
        bus0.cmd_op = 2'd1; bus0.cmd_len = 6'd10; bus0.cmd_data = 32'h3FF; bus0.cmd_valid = 1'b1;
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n0 - base >= 6) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("mid_reach6", ok, 64'd1);
        rst = 1'b1;
        r0  = nrsp0;
        @(negedge clk);
        chk("mid_tck",   tck0, 64'd0);
        chk("mid_tms",   tms0, 64'd1);
        chk("mid_tdi",   tdi0, 64'd0);
        chk("mid_ready", bus0.cmd_ready, AUTO ? 64'd0 : 64'd1);
        chk("mid_rspv",  bus0.rsp_valid, 64'd0);
        rst  = 1'b0;
        base = n0;
        if (AUTO) begin
            wait_ready(ok);
            chk("mid_auto_ready", ok, 64'd1);
            chk("mid_auto_rises", n0 - base, 64'd8);
        end else begin
            repeat (80) @(negedge clk);
            chk("mid_quiet", n0 - base, 64'd0);
        end
        chk("mid_norsp", nrsp0 - r0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
